// File: rtl/axis_frame_len_enforce.sv
// AXI-Stream frame length enforcer: truncates frames longer than MAX_LEN (marking them bad and
// dropping the tail); optional short-frame padding to MIN_LEN when AXIS_FRAME_LEN_PAD_EN is defined.
module axis_frame_len_enforce #(
  parameter int unsigned           DATA_WIDTH           = 8,
  parameter bit                    KEEP_ENABLE          = (DATA_WIDTH > 8),
  parameter int unsigned           KEEP_WIDTH           = DATA_WIDTH / 8,
  parameter int unsigned           USER_WIDTH           = 1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = USER_WIDTH'(1'b1),
  parameter int unsigned           LEN_WIDTH            = 16,
  parameter int unsigned           MAX_LEN              = 1518,
  parameter int unsigned           MIN_LEN              = 60
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic [LEN_WIDTH-1:0]  status_frame_len,
  output logic                  status_frame_valid,
  output logic                  status_truncated,
  output logic                  status_padded
);

  if (MAX_LEN == 0 || MAX_LEN >= (64'd1 << LEN_WIDTH) || MIN_LEN == 0 || MIN_LEN > MAX_LEN)
  begin : gen_param_err
    $error("axis_frame_len_enforce: illegal MAX_LEN/MIN_LEN for LEN_WIDTH");
  end

  localparam logic [LEN_WIDTH-1:0] LenMaxLast = LEN_WIDTH'(MAX_LEN - 1);

`ifdef AXIS_FRAME_LEN_PAD_EN
  localparam logic [LEN_WIDTH-1:0] LenMinLast = LEN_WIDTH'(MIN_LEN - 1);
  typedef enum logic [1:0] {StPass, StDrop, StPad} state_e;
  logic [USER_WIDTH-1:0] user_lat_q, user_lat_d;
`else
  typedef enum logic [0:0] {StPass, StDrop} state_e;
`endif

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [KEEP_WIDTH-1:0] keep_q, keep_d;
  logic [USER_WIDTH-1:0] user_q, user_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  fv_q, fv_d;
  logic                  trunc_q, trunc_d;
  logic                  pad_q, pad_d;
  logic                  ld;
  logic                  load;

  always_comb begin
    ld            = m_axis_tready | ~valid_q;
    load          = 1'b0;
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    data_d        = data_q;
    keep_d        = keep_q;
    user_d        = user_q;
    last_d        = last_q;
    valid_d       = ld ? 1'b0 : valid_q;
    len_d         = len_q;
    fv_d          = 1'b0;
    trunc_d       = 1'b0;
    pad_d         = 1'b0;
    s_axis_tready = 1'b0;
`ifdef AXIS_FRAME_LEN_PAD_EN
    user_lat_d    = user_lat_q;
`endif

    case (state_q)
      StPass: begin
        s_axis_tready = ld;
        if (s_axis_tvalid && ld) begin
          load   = 1'b1;
          data_d = s_axis_tdata;
          keep_d = KEEP_ENABLE ? s_axis_tkeep : '1;
          user_d = s_axis_tuser;
          last_d = s_axis_tlast;
          // Beat MAX_LEN without tlast: close the frame here and discard the remainder.
          if (!s_axis_tlast && beat_cnt_q == LenMaxLast) begin
            last_d  = 1'b1;
            user_d  = s_axis_tuser | USER_BAD_FRAME_VALUE;
            trunc_d = 1'b1;
            state_d = StDrop;
          end
`ifdef AXIS_FRAME_LEN_PAD_EN
          if (s_axis_tlast && beat_cnt_q < LenMinLast) begin
            last_d     = 1'b0;
            user_lat_d = s_axis_tuser;
            state_d    = StPad;
          end
`endif
        end
      end
      StDrop: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_d = StPass;
      end
`ifdef AXIS_FRAME_LEN_PAD_EN
      StPad: begin
        if (ld) begin
          load   = 1'b1;
          data_d = '0;
          keep_d = '1;
          user_d = '0;
          last_d = 1'b0;
          if (beat_cnt_q == LenMinLast) begin
            last_d  = 1'b1;
            user_d  = user_lat_q;
            pad_d   = 1'b1;
            state_d = StPass;
          end
        end
      end
`endif
      default: state_d = StPass;
    endcase

    if (load) begin
      valid_d = 1'b1;
      if (last_d) begin
        beat_cnt_d = '0;
        len_d      = beat_cnt_q + 1'b1;
        fv_d       = 1'b1;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StPass;
      beat_cnt_q <= '0;
      data_q     <= '0;
      keep_q     <= '0;
      user_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      len_q      <= '0;
      fv_q       <= 1'b0;
      trunc_q    <= 1'b0;
      pad_q      <= 1'b0;
`ifdef AXIS_FRAME_LEN_PAD_EN
      user_lat_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      data_q     <= data_d;
      keep_q     <= keep_d;
      user_q     <= user_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      len_q      <= len_d;
      fv_q       <= fv_d;
      trunc_q    <= trunc_d;
      pad_q      <= pad_d;
`ifdef AXIS_FRAME_LEN_PAD_EN
      user_lat_q <= user_lat_d;
`endif
    end
  end

  assign m_axis_tdata       = data_q;
  assign m_axis_tkeep       = keep_q;
  assign m_axis_tvalid      = valid_q;
  assign m_axis_tlast       = last_q;
  assign m_axis_tuser       = user_q;
  assign status_frame_len   = len_q;
  assign status_frame_valid = fv_q;
  assign status_truncated   = trunc_q;
`ifdef AXIS_FRAME_LEN_PAD_EN
  assign status_padded      = pad_q;
`else
  assign status_padded      = 1'b0;
`endif

endmodule

// File: tb/tb_axis_frame_len_enforce.sv
// Randomized bench for axis_frame_len_enforce; expected output frames and status are derived
// per frame from the length rules (truncate above MaxLen, optional pad below MinLen).
module tb_axis_frame_len_enforce;
  localparam int MaxLen = 8;
  localparam int MinLen = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  s_axis_tdata = '0;
  logic [0:0]  s_axis_tkeep = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [0:0]  s_axis_tuser = '0;
  logic [7:0]  m_axis_tdata;
  logic [0:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic [0:0]  m_axis_tuser;
  logic [15:0] status_frame_len;
  logic        status_frame_valid;
  logic        status_truncated;
  logic        status_padded;

  axis_frame_len_enforce #(
    .DATA_WIDTH(8), .USER_WIDTH(1), .LEN_WIDTH(16), .MAX_LEN(MaxLen), .MIN_LEN(MinLen)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .status_frame_len(status_frame_len), .status_frame_valid(status_frame_valid),
    .status_truncated(status_truncated), .status_padded(status_padded)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; logic last; logic user; int src; } beat_t;
  typedef struct { int len; logic trunc; logic pad; } stat_t;

  beat_t exp_q[$];
  stat_t st_q[$];
  int    acc_cyc[$];
  int    n_tests = 0;
  int    n_fail = 0;
  int    cyc = 0;
  bit    rdy_rand = 1'b0;
  bit    mon_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1;
    m_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: ordering, content, latency, hold stability and status pulses.
  logic       hold_v = 1'b0;
  logic [7:0] hold_d;
  logic       hold_l, hold_u;
  always @(negedge clk) begin : mon
    beat_t e;
    stat_t s;
    if (mon_en && !rst) begin
      if (hold_v) begin
        check_eq("hold_valid", m_axis_tvalid, 1);
        check_eq("hold_data", m_axis_tdata, hold_d);
        check_eq("hold_last", m_axis_tlast, hold_l);
        check_eq("hold_user", m_axis_tuser, hold_u);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) check_eq("extra_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          check_eq("data", m_axis_tdata, e.data);
          check_eq("last", m_axis_tlast, e.last);
          check_eq("user", m_axis_tuser, e.user);
          check_eq("keep", m_axis_tkeep, 1);
          if (!rdy_rand && e.src >= 0) check_eq("latency", cyc, acc_cyc[e.src] + 1);
        end
      end
      if (status_frame_valid) begin
        if (st_q.size() == 0) check_eq("extra_status", 1, 0);
        else begin
          s = st_q.pop_front();
          check_eq("frame_len", status_frame_len, s.len);
          check_eq("truncated", status_truncated, s.trunc);
          check_eq("padded", status_padded, s.pad);
        end
      end else if (status_truncated || status_padded) begin
        check_eq("stray_status", {status_truncated, status_padded}, 0);
      end
      hold_v <= m_axis_tvalid && !m_axis_tready;
      hold_d <= m_axis_tdata;
      hold_l <= m_axis_tlast;
      hold_u <= m_axis_tuser;
    end else begin
      hold_v <= 1'b0;
    end
  end

  // Builds the expected output of a len-beat frame, then drives its first n_drive beats.
  task automatic send_frame(input int len, input int n_drive);
    int         base = acc_cyc.size();
    logic [7:0] d[$];
    logic       u[$];
    int         n_out;
    bit         trunc;
    bit         pad = 1'b0;
    int         t;
    beat_t      b;
    stat_t      s;
    for (int i = 0; i < len; i++) begin
      d.push_back(8'($urandom));
      u.push_back(1'($urandom_range(0, 1)));
    end
    trunc = len > MaxLen;
    n_out = trunc ? MaxLen : len;
`ifdef AXIS_FRAME_LEN_PAD_EN
    pad = !trunc && len < MinLen;
`endif
    for (int i = 0; i < n_out; i++) begin
      b.data = d[i];
      b.user = (trunc && i == n_out - 1) ? 1'b1 : u[i];
      b.last = (i == n_out - 1) && !pad;
      b.src  = base + i;
      exp_q.push_back(b);
    end
    if (pad) begin
      for (int j = len; j < MinLen; j++) begin
        b.data = 8'h00;
        b.last = (j == MinLen - 1);
        b.user = b.last ? u[len-1] : 1'b0;
        b.src  = -1;
        exp_q.push_back(b);
      end
    end
    s.len   = pad ? MinLen : n_out;
    s.trunc = trunc;
    s.pad   = pad;
    st_q.push_back(s);

    for (int i = 0; i < n_drive; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d[i];
      s_axis_tuser  = u[i];
      s_axis_tkeep  = 1'($urandom);
      s_axis_tlast  = (i == len - 1);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!s_axis_tready && t < 500);
      if (!s_axis_tready) begin
        check_eq("tready_timeout", 0, 1);
        s_axis_tvalid = 1'b0;
        return;
      end
      acc_cyc.push_back(cyc);
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || st_q.size() != 0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0 || st_q.size() != 0) check_eq("drain_timeout", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_set(input int n_rand);
    send_frame(5, 5);
    send_frame(12, 12);
    send_frame(8, 8);
    send_frame(3, 3);
    send_frame(1, 1);
    send_frame(2, 2);
    send_frame(9, 9);
    for (int i = 0; i < n_rand; i++) begin
      int l = $urandom_range(1, 14);
      send_frame(l, l);
    end
    drain();
  endtask

  initial begin
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_tvalid", m_axis_tvalid, 0);
    check_eq("rst_status", {status_frame_valid, status_truncated, status_padded}, 0);
    check_eq("rst_len", status_frame_len, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check_eq("idle_tready", s_axis_tready, 1);
    @(posedge clk);
    #1;

    rdy_rand = 1'b0;
    run_set(10);
    rdy_rand = 1'b1;
    run_set(25);
    rdy_rand = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while discarding the tail of an over-long frame.
    @(posedge clk);
    #1;
    send_frame(12, 10);
    #3;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("drop_rst_tvalid", m_axis_tvalid, 0);
    check_eq("drop_rst_status", {status_frame_valid, status_truncated}, 0);
    exp_q.delete();
    st_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    send_frame(3, 3);
    send_frame(12, 12);
    send_frame(4, 4);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
